tmss_bios_loader: RTL and testbench

- Holds the TMSS boot ROM image and sits directly upstream of the TMSS block.
- Receives the image as a byte stream over the HPS ioctl download channel and packs it into 16-bit words in an internal 1K x 16 RAM.
- After download, validates the image, serves tmss_data for the tmss_address driven by the TMSS block, and drives that block's tmss_enable.
- A missing, short or corrupt image keeps TMSS disabled, so the console boots as a non-TMSS unit.

---
 rtl/tmss_bios_loader_pkg.sv | 21 ++
 rtl/tmss_bios_loader_if.sv | 28 ++
 rtl/tmss_bios_loader_bram.sv | 27 ++
 rtl/tmss_bios_loader.sv | 133 +++++++++++++
 tb/tb_tmss_bios_loader.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/tmss_bios_loader_pkg.sv
// Shared types and constants for the TMSS boot ROM loader.
package tmss_pkg;

   // Loader life cycle, from power-up through download, validation and use
   typedef enum logic [2:0] {
      EMPTY = 3'd0,
      LOAD  = 3'd1,
      CHECK = 3'd2,
      READY = 3'd3,
      ERROR = 3'd4
   } tmss_state_t;

   // The two words that must sit at the signature location ("SEGA")
   localparam logic [15:0] TMSS_SIG_HI = 16'h5345;
   localparam logic [15:0] TMSS_SIG_LO = 16'h4741;

   // ROM geometry: 1K words of 16 bits
   localparam int TMSS_ROM_WORDS = 1024;
   localparam int TMSS_ADDR_W    = 10;

endpackage

// File: rtl/tmss_bios_loader_if.sv
// HPS ioctl download channel as seen by the loader.
interface tmss_bios_loader_if;

   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;

   // The HPS side drives the download channel
   modport master (
      output ioctl_download,
      output ioctl_index,
      output ioctl_wr,
      output ioctl_addr,
      output ioctl_dout
   );

   // The loader only observes the download channel
   modport slave (
      input ioctl_download,
      input ioctl_index,
      input ioctl_wr,
      input ioctl_addr,
      input ioctl_dout
   );

endinterface

// File: rtl/tmss_bios_loader_bram.sv
// Simple dual-port 1024x16 RAM holding the TMSS image; no reset.
module tmss_bram
   import tmss_pkg::*;
(
   input  logic                   clk,
   input  logic                   we,
   input  logic [TMSS_ADDR_W-1:0] waddr,
   input  logic [15:0]            wdata,
   input  logic [TMSS_ADDR_W-1:0] raddr,
   output logic [15:0]            rdata
);

   logic [15:0] mem [TMSS_ROM_WORDS];

   // Write port A: one word per strobe from the download packer
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read port B: registered read, old data when colliding with a write
   always_ff @(posedge clk) begin
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/tmss_bios_loader.sv
// Downloads, packs, validates and serves the TMSS boot ROM image.
module tmss_bios_loader
   import tmss_pkg::*;
#(
   parameter logic [7:0]             BIOS_INDEX = 8'h02,
   parameter int                     BIOS_BYTES = 2048,
   parameter logic [TMSS_ADDR_W-1:0] SIG_WORD   = 10'h080
)(
   input  logic                   MCLK,
   input  logic                   reset,
   input  logic                   cfg_enable,
   tmss_bios_loader_if.slave      ioctl,
   input  logic [TMSS_ADDR_W-1:0] tmss_address,
   output logic [15:0]            tmss_data,
   output logic                   tmss_enable,
   output logic                   load_busy,
   output logic                   load_error
);

   tmss_state_t            state;
   logic                   download_prev;
   logic [11:0]            byte_count;
   logic [7:0]             high_byte;
   logic                   oversize;
   logic [1:0]             check_phase;
   logic                   sig_hi_ok;

   logic                   index_match;
   logic                   start;
   logic                   accept;
   logic                   addr_in_range;
   logic                   ram_we;
   logic [TMSS_ADDR_W-1:0] ram_raddr;
   logic [15:0]            ram_q;

   assign index_match   = (ioctl.ioctl_index == BIOS_INDEX);
   assign start         = ioctl.ioctl_download && !download_prev && index_match;
   assign accept        = (state == LOAD) && ioctl.ioctl_download && ioctl.ioctl_wr && index_match;
   assign addr_in_range = (ioctl.ioctl_addr < 25'(BIOS_BYTES));

   // An odd byte completes a word; bytes past the image end never reach the RAM
   assign ram_we = accept && ioctl.ioctl_addr[0] && addr_in_range;

   // During validation the signature words own the read port, otherwise the TMSS block does
   always_comb begin
      ram_raddr = tmss_address;
      if (state == CHECK) begin
         ram_raddr = (check_phase == 2'd0) ? SIG_WORD : (SIG_WORD + 10'd1);
      end
   end

   tmss_bram u_bram (
      .clk   (MCLK),
      .we    (ram_we),
      .waddr (ioctl.ioctl_addr[10:1]),
      .wdata ({high_byte, ioctl.ioctl_dout}),
      .raddr (ram_raddr),
      .rdata (ram_q)
   );

   // Loader state machine: download tracking, byte packing and signature validation
   always_ff @(posedge MCLK or posedge reset) begin
      if (reset) begin
         state         <= EMPTY;
         download_prev <= 1'b0;
         byte_count    <= 12'd0;
         high_byte     <= 8'd0;
         oversize      <= 1'b0;
         check_phase   <= 2'd0;
         sig_hi_ok     <= 1'b0;
         load_error    <= 1'b0;
      end else begin
         download_prev <= ioctl.ioctl_download;
         if (start && (state != LOAD)) begin
            state       <= LOAD;
            byte_count  <= 12'd0;
            oversize    <= 1'b0;
            check_phase <= 2'd0;
            load_error  <= 1'b0;
         end else begin
            case (state)
               LOAD: begin
                  if (accept) begin
                     if (!ioctl.ioctl_addr[0]) begin
                        high_byte <= ioctl.ioctl_dout;
                     end
                     if (byte_count != 12'hFFF) begin
                        byte_count <= byte_count + 12'd1;
                     end
                     if (!addr_in_range) begin
                        oversize <= 1'b1;
                     end
                  end
                  if (!ioctl.ioctl_download) begin
                     state       <= CHECK;
                     check_phase <= 2'd0;
                  end
               end
               CHECK: begin
                  case (check_phase)
                     2'd0: begin
                        check_phase <= 2'd1;
                     end
                     2'd1: begin
                        sig_hi_ok   <= (ram_q == TMSS_SIG_HI);
                        check_phase <= 2'd2;
                     end
                     default: begin
                        check_phase <= 2'd0;
                        if (sig_hi_ok && (ram_q == TMSS_SIG_LO) &&
                            (byte_count == 12'(BIOS_BYTES)) && !oversize) begin
                           state <= READY;
                        end else begin
                           state      <= ERROR;
                           load_error <= 1'b1;
                        end
                     end
                  endcase
               end
               default: begin
                  state <= state;
               end
            endcase
         end
      end
   end

   // ROM data is only visible once a validated image is in place
   assign tmss_data   = (state == READY) ? ram_q : 16'h0000;
   assign tmss_enable = (state == READY) && cfg_enable;
   assign load_busy   = (state == LOAD) || (state == CHECK);

endmodule

// File: tb/tb_tmss_bios_loader.sv
// Randomized self-checking bench for the TMSS boot ROM loader.
module tb_tmss_bios_loader;

   logic        MCLK = 1'b0;
   logic        reset;
   logic        cfg_enable;
   logic [9:0]  tmss_address;
   logic [15:0] tmss_data;
   logic        tmss_enable;
   logic        load_busy;
   logic        load_error;

   tmss_bios_loader_if intf ();

   tmss_bios_loader dut (
      .MCLK         (MCLK),
      .reset        (reset),
      .cfg_enable   (cfg_enable),
      .ioctl        (intf),
      .tmss_address (tmss_address),
      .tmss_data    (tmss_data),
      .tmss_enable  (tmss_enable),
      .load_busy    (load_busy),
      .load_error   (load_error)
   );

   // 100 MHz system clock
   always #5 MCLK = ~MCLK;

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  img [4096];
   logic [15:0] model_mem [1024];
   logic        model_ready;
   logic        model_error;

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Advance one clock and settle just after the edge
   task automatic tick();
      @(posedge MCLK);
      #1;
   endtask

   // Random image with a correct signature at byte 0x100
   task automatic makeImage();
      for (int i = 0; i < 4096; i++) img[i] = 8'($urandom_range(0, 255));
      img[256] = 8'h53;
      img[257] = 8'h45;
      img[258] = 8'h47;
      img[259] = 8'h41;
   endtask

   // Stream nbytes of img as one download; abort_at >= 0 pulses reset at that byte
   task automatic applyStimulus(input logic [7:0] index, input int nbytes, input int abort_at);
      logic [7:0] hi;
      logic       over;
      int         count;
      int         k;
      bit         matched;
      hi      = 8'h00;
      over    = 1'b0;
      count   = 0;
      matched = (index == 8'h02);
      intf.ioctl_index    = index;
      intf.ioctl_download = 1'b1;
      tick();
      checkOutput(matched ? "busy_start" : "busy_foreign", 32'(load_busy), 32'(matched));
      tick();
      for (int i = 0; i < nbytes; i++) begin
         if (i == abort_at) begin
            reset = 1'b1;
            #2;
            checkOutput("abort_enable", 32'(tmss_enable), 32'd0);
            checkOutput("abort_busy", 32'(load_busy), 32'd0);
            checkOutput("abort_error", 32'(load_error), 32'd0);
            intf.ioctl_download = 1'b0;
            tick();
            reset       = 1'b0;
            model_ready = 1'b0;
            model_error = 1'b0;
            tick();
            return;
         end
         intf.ioctl_wr   = 1'b1;
         intf.ioctl_addr = 25'(i);
         intf.ioctl_dout = img[i];
         tick();
         intf.ioctl_wr = 1'b0;
         if (matched) begin
            if (count < 4095) count++;
            if (i >= 2048) over = 1'b1;
            else if (i % 2 == 0) hi = img[i];
            else model_mem[i / 2] = {hi, img[i]};
         end
         if ((i != nbytes - 1) && ($urandom_range(0, 3) == 0)) tick();
      end
      intf.ioctl_download = 1'b0;
      if (matched) begin
         k = 0;
         while (load_busy && (k < 20)) begin
            tick();
            k++;
         end
         checkOutput("busy_timeout", 32'(load_busy), 32'd0);
         model_ready = (count == 2048) && !over &&
                       (model_mem[128] == 16'h5345) && (model_mem[129] == 16'h4741);
         model_error = !model_ready;
      end else begin
         repeat (4) tick();
      end
   endtask

   // Compare status outputs and a handful of random ROM reads against the model
   task automatic checkState(input string tag);
      logic [9:0] a;
      checkOutput({tag, "_enable"}, 32'(tmss_enable), 32'(model_ready && cfg_enable));
      checkOutput({tag, "_error"}, 32'(load_error), 32'(model_error));
      checkOutput({tag, "_busy"}, 32'(load_busy), 32'd0);
      for (int n = 0; n < 6; n++) begin
         a = 10'($urandom_range(0, 1023));
         tmss_address = a;
         tick();
         checkOutput({tag, "_data"}, 32'(tmss_data), model_ready ? 32'(model_mem[a]) : 32'd0);
      end
   endtask

   initial begin
      reset               = 1'b1;
      cfg_enable          = 1'b1;
      tmss_address        = 10'd0;
      intf.ioctl_download = 1'b0;
      intf.ioctl_index    = 8'h00;
      intf.ioctl_wr       = 1'b0;
      intf.ioctl_addr     = 25'd0;
      intf.ioctl_dout     = 8'h00;
      model_ready         = 1'b0;
      model_error         = 1'b0;
      for (int i = 0; i < 1024; i++) model_mem[i] = 16'h0000;
      #12;
      checkOutput("reset_data", 32'(tmss_data), 32'd0);
      checkOutput("reset_enable", 32'(tmss_enable), 32'd0);
      checkOutput("reset_busy", 32'(load_busy), 32'd0);
      checkOutput("reset_error", 32'(load_error), 32'd0);
      reset = 1'b0;
      tick();

      $display("[TB] valid load");
      makeImage();
      applyStimulus(8'h02, 2048, -1);
      checkOutput("valid_ready", 32'(model_ready), 32'd1);
      checkState("valid");
      tmss_address = 10'h080;
      tick();
      checkOutput("sig_read", 32'(tmss_data), 32'h5345);
      cfg_enable = 1'b0;
      #1;
      checkOutput("cfg_off_enable", 32'(tmss_enable), 32'd0);
      cfg_enable = 1'b1;
      #1;
      checkOutput("cfg_on_enable", 32'(tmss_enable), 32'd1);

      $display("[TB] foreign index");
      for (int i = 0; i < 4096; i++) img[i] = 8'($urandom_range(0, 255));
      applyStimulus(8'h00, 4096, -1);
      checkState("foreign");

      $display("[TB] bad signature");
      makeImage();
      img[259] = 8'h00;
      applyStimulus(8'h02, 2048, -1);
      checkState("badsig");

      $display("[TB] short image then reload");
      makeImage();
      applyStimulus(8'h02, 2047, -1);
      checkState("short");
      makeImage();
      applyStimulus(8'h02, 2048, -1);
      checkState("reload");

      $display("[TB] oversize image");
      makeImage();
      applyStimulus(8'h02, 2050, -1);
      checkState("oversize");
      checkOutput("oversize_word0", 32'(dut.u_bram.mem[0]), 32'(model_mem[0]));

      $display("[TB] reset during load");
      makeImage();
      applyStimulus(8'h02, 2048, 1000);
      checkState("aborted");

      $display("[TB] final reload");
      makeImage();
      applyStimulus(8'h02, 2048, -1);
      checkState("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case a task loop never returns
   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
